// File: rtl/abc_producer_pkg.sv
// Shared constants for the abc_producer operand handshake block.
package abc_producer_pkg;

   localparam int unsigned NDefault = 4;
   localparam int unsigned SentW    = 8;

   // Handshake FSM encoding
   localparam logic [1:0] S0 = 2'd0;
   localparam logic [1:0] S1 = 2'd1;
   localparam logic [1:0] S2 = 2'd2;

endpackage

// File: rtl/abc_fifo.sv
// Operand-pair FIFO feeding the abc_producer handshake FSM.
module abc_fifo
   import abc_producer_pkg::*;
#(
   parameter int unsigned N     = NDefault,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     _reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [2*N-1:0]           din,
   output logic [2*N-1:0]           dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   logic [2*N-1:0]  mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]   count_q, count_d;
   logic            wr_en, rd_en;

   // full is sampled before any pop on the same edge, so a push while full is always dropped
   assign wr_en = push & ~full;
   assign rd_en = pop & ~empty;

   always_comb begin
      count_d = count_q;
      if (wr_en && !rd_en) begin
         count_d = count_q + 1'b1;
      end else if (!wr_en && rd_en) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge _reset) begin
      if (!_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;
   // DEPTH is a power of two, so the count MSB alone marks a full FIFO
   assign full  = count_q[PtrW];
   assign empty = (count_q == '0);

endmodule

// File: rtl/abc_producer.sv
// Producer side of the _dav/rfd handshake: FIFO-buffered operand pairs presented one at a time.
module abc_producer
   import abc_producer_pkg::*;
#(
   parameter int unsigned N     = NDefault,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   _reset,
   input  logic                   push,
   input  logic [N-1:0]           a_in,
   input  logic [N-1:0]           b_in,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   _dav,
   input  logic                   rfd,
   output logic [N-1:0]           a,
   output logic [N-1:0]           b,
   output logic [SentW-1:0]       sent
);

   logic [1:0]       state_q, state_d;
   logic             dav_q, dav_d;
   logic [N-1:0]     a_q, a_d, b_q, b_d;
   logic [SentW-1:0] sent_q, sent_d;
   logic             pop;
   logic             fifo_empty;
   logic [2*N-1:0]   fifo_dout;

   abc_fifo #(
      .N     (N),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock  (clock),
      ._reset (_reset),
      .push   (push),
      .pop    (pop),
      .din    ({a_in, b_in}),
      .dout   (fifo_dout),
      .count  (count),
      .full   (full),
      .empty  (fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      dav_d   = dav_q;
      a_d     = a_q;
      b_d     = b_q;
      sent_d  = sent_q;
      pop     = 1'b0;
      case (state_q)
         S0: begin
            if (!fifo_empty && rfd) begin
               a_d     = fifo_dout[2*N-1:N];
               b_d     = fifo_dout[N-1:0];
               dav_d   = 1'b0;
               state_d = S1;
            end
         end
         S1: begin
            // rfd low means the consumer has taken the pair
            if (!rfd) begin
               dav_d   = 1'b1;
               pop     = 1'b1;
               sent_d  = sent_q + 1'b1;
               state_d = S2;
            end
         end
         S2: begin
            if (rfd) state_d = S0;
         end
         default: begin
            state_d = S0;
            dav_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock or negedge _reset) begin
      if (!_reset) begin
         state_q <= S0;
         dav_q   <= 1'b1;
         a_q     <= '0;
         b_q     <= '0;
         sent_q  <= '0;
      end else begin
         state_q <= state_d;
         dav_q   <= dav_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sent_q  <= sent_d;
      end
   end

   assign _dav = dav_q;
   assign a    = a_q;
   assign b    = b_q;
   assign sent = sent_q;

endmodule
